tremolo_mod: RTL and testbench

Amplitude modulator for the pedal's tremolo effect, directly downstream of `nco_cos`. It takes the signed cosine `wav` that `nco_cos` produces as the LFO, converts it to a unipolar gain scaled by a depth control, and multiplies each audio sample by that gain. Samples move through a 3-stage stallable pipeline with valid/ready handshakes on both sides, between the audio input path and the output codec path.

---
 rtl/audio_pkg.sv | 9 +
 rtl/tremolo_mod_if.sv | 13 +
 rtl/tremolo_gain.sv | 57 +++++
 rtl/tremolo_mod.sv | 65 ++++++
 tb/tb_tremolo_mod.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and fixed-point constants for the pedal's effect chain.
package audio_pkg;

    typedef logic signed [23:0] sample_t;

    localparam logic [23:0]  UNITY_Q23   = 24'h80_0000;
    localparam int unsigned  DEPTH_SHIFT = 8;

endpackage

// File: rtl/tremolo_mod_if.sv
// Valid/ready sample stream carrying one signed audio word per transfer.
interface tremolo_mod_if #(
    parameter int unsigned WIDTH = 24
) ();

    logic                    valid;
    logic                    ready;
    logic signed [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/tremolo_gain.sv
// Stages 1-2 of the tremolo: LFO cosine to unipolar gain scaled by depth.
module tremolo_gain
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DEPTH_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv_i,
    input  logic                    valid_i,
    input  logic                    en_i,
    input  logic signed [WIDTH-1:0] wav_i,
    input  logic [DEPTH_WIDTH-1:0]  depth_i,
    output logic                    valid_o,
    output logic [WIDTH-1:0]        gain_o
);

    localparam int unsigned      ProdW = WIDTH + DEPTH_WIDTH;
    localparam logic [WIDTH-1:0] Unity = WIDTH'(UNITY_Q23);

    logic [WIDTH-1:0]       offs, u_d, d_d, d_q, gain_d, gain_q;
    logic [DEPTH_WIDTH-1:0] depth_q;
    logic [ProdW-1:0]       prod;
    logic                   en_q, valid1_q, valid2_q;

    always_comb begin
        // wav + 2^23 is the offset-binary form of wav: flip the sign bit.
        offs   = {~wav_i[WIDTH-1], wav_i[WIDTH-2:0]};
        u_d    = offs >> 1;
        d_d    = Unity - u_d;
        prod   = ProdW'(d_q) * ProdW'(depth_q);
        gain_d = en_q ? Unity - WIDTH'(prod >> DEPTH_SHIFT) : Unity;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            en_q     <= 1'b0;
            d_q      <= '0;
            depth_q  <= '0;
            gain_q   <= Unity;
        end else if (adv_i) begin
            valid1_q <= valid_i;
            en_q     <= en_i;
            d_q      <= d_d;
            depth_q  <= depth_i;
            valid2_q <= valid1_q;
            gain_q   <= gain_d;
        end
    end

    assign valid_o = valid2_q;
    assign gain_o  = gain_q;

endmodule

// File: rtl/tremolo_mod.sv
// Tremolo amplitude modulator: 3-stage stallable pipeline, sample times LFO gain.
module tremolo_mod
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned WAV_WIDTH   = 24,
    parameter int unsigned DEPTH_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [WAV_WIDTH-1:0] wav,
    input  logic [DEPTH_WIDTH-1:0]      depth,
    tremolo_mod_if.slave                s,
    tremolo_mod_if.master               m
);

    logic                    stall, adv, valid2, valid3_q;
    logic [WIDTH-1:0]        gain;
    logic signed [WIDTH-1:0] data1_q, data2_q, m_data_q, m_data_d;
    logic signed [2*WIDTH:0] prod;

    assign stall   = valid3_q && !m.ready;
    assign adv     = !stall;
    assign s.ready = adv;

    tremolo_gain #(
        .WIDTH       (WIDTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_gain (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (adv),
        .valid_i (s.valid),
        .en_i    (en),
        .wav_i   (wav),
        .depth_i (depth),
        .valid_o (valid2),
        .gain_o  (gain)
    );

    // Low 2W+1 bits of the product are sign-correct; gain <= 2^23 keeps the result in range.
    always_comb begin
        prod     = {{(WIDTH+1){data2_q[WIDTH-1]}}, data2_q} * {{(WIDTH+1){1'b0}}, gain};
        m_data_d = WIDTH'(prod >>> (WIDTH-1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data1_q  <= '0;
            data2_q  <= '0;
            valid3_q <= 1'b0;
            m_data_q <= '0;
        end else if (adv) begin
            data1_q  <= s.data;
            data2_q  <= data1_q;
            valid3_q <= valid2;
            m_data_q <= m_data_d;
        end
    end

    assign m.valid = valid3_q;
    assign m.data  = m_data_q;

endmodule

// File: tb/tb_tremolo_mod.sv
// Directed bench for tremolo_mod: gain arithmetic, latency, backpressure, mid-stream reset.
module tb_tremolo_mod;
    import audio_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic signed [23:0] wav;
    logic [7:0]        depth;

    int n_checks = 0;
    int n_errors = 0;

    tremolo_mod_if #(.WIDTH(24)) s_if ();
    tremolo_mod_if #(.WIDTH(24)) m_if ();

    tremolo_mod #(
        .WIDTH       (24),
        .WAV_WIDTH   (24),
        .DEPTH_WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .wav   (wav),
        .depth (depth),
        .s     (s_if),
        .m     (m_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample; side inputs are scrambled after accept to show they travel with it.
    task automatic send_one(input string tag, input logic [23:0] w, input logic [7:0] dp,
                            input logic e, input logic [23:0] din, input logic [23:0] exp);
        wav = w; depth = dp; en = e;
        s_if.data = din; s_if.valid = 1'b1; m_if.ready = 1'b1;
        #1;
        check({tag, "/s_ready"}, 32'(s_if.ready), 32'd1);
        step();
        s_if.valid = 1'b0; wav = 24'h000000; depth = 8'hAA; en = ~e; s_if.data = 24'h5A5A5A;
        check({tag, "/valid_e1"}, 32'(m_if.valid), 32'd0);
        step();
        check({tag, "/valid_e2"}, 32'(m_if.valid), 32'd0);
        step();
        check({tag, "/valid_e3"}, 32'(m_if.valid), 32'd1);
        check({tag, "/data"}, {8'h00, m_if.data}, {8'h00, exp});
        step();
        check({tag, "/drop"}, 32'(m_if.valid), 32'd0);
    endtask

    int           next_in, next_out, in_flight, stall_left, cyc, seen_cnt;
    bit           seen, was_stall, acc, emit;
    logic [23:0]  hold_data;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; wav = '0; depth = '0;
        s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b0;
        step(); step();
        check("rst/m_valid", 32'(m_if.valid), 32'd0);
        check("rst/m_data", {8'h00, m_if.data}, 32'd0);
        check("rst/s_ready", 32'(s_if.ready), 32'd1);
        rst = 1'b0;
        step();
        check("idle/s_ready", 32'(s_if.ready), 32'd1);

        send_one("d0", 24'h800001, 8'd0, 1'b1, 24'h123456, 24'h123456);
        send_one("d255_pos", 24'h800001, 8'd255, 1'b1, 24'h400000, 24'h004000);
        send_one("d255_neg", 24'h800001, 8'd255, 1'b1, 24'hC00000, 24'hFFC000);
        send_one("peak", 24'h7FFFFF, 8'd255, 1'b1, 24'hC00000, 24'hC00000);
        send_one("bypass", 24'h800001, 8'd255, 1'b0, 24'h7FFFFF, 24'h7FFFFF);
        // wav=0, depth=128: gain = 0.75; -1 * 0.75 floors back to -1.
        send_one("mid", 24'h000000, 8'd128, 1'b1, 24'h400000, 24'h300000);
        send_one("floor", 24'h000000, 8'd128, 1'b1, 24'hFFFFFF, 24'hFFFFFF);

        // Backpressure: stream 1..6, hold m_ready low 5 cycles once output first appears.
        wav = '0; depth = '0; en = 1'b1;
        next_in = 1; next_out = 1; in_flight = 0; stall_left = 5; cyc = 0;
        seen = 1'b0; was_stall = 1'b0; hold_data = '0;
        while (next_out <= 6 && cyc < 60) begin
            if (m_if.valid) seen = 1'b1;
            m_if.ready = !(seen && stall_left > 0);
            s_if.valid = (next_in <= 6);
            s_if.data  = 24'(next_in);
            #1;
            if (was_stall) check("bp/hold", {8'h00, m_if.data}, {8'h00, hold_data});
            if (m_if.valid && !m_if.ready) begin
                check("bp/s_ready_low", 32'(s_if.ready), 32'd0);
                check("bp/full", in_flight, 3);
                stall_left--;
                hold_data = m_if.data;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            acc  = s_if.valid && s_if.ready;
            emit = m_if.valid && m_if.ready;
            if (emit) begin
                check("bp/order", {8'h00, m_if.data}, next_out);
                next_out++;
            end
            step();
            if (acc) begin next_in++; in_flight++; end
            if (emit) in_flight--;
            cyc++;
        end
        check("bp/all_out", next_out, 7);
        check("bp/stalled", stall_left, 0);
        s_if.valid = 1'b0; m_if.ready = 1'b1;
        seen_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_if.valid) seen_cnt++;
            step();
        end
        check("bp/no_dup", seen_cnt, 0);

        // Reset with two samples in flight, none output yet.
        m_if.ready = 1'b1; depth = '0; en = 1'b1;
        s_if.valid = 1'b1; s_if.data = 24'h111111;
        step();
        s_if.data = 24'h222222;
        step();
        s_if.valid = 1'b0;
        rst = 1'b1;
        step();
        check("mrst/m_valid", 32'(m_if.valid), 32'd0);
        check("mrst/m_data", {8'h00, m_if.data}, 32'd0);
        rst = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_if.valid) seen_cnt++;
            step();
        end
        check("mrst/no_stale", seen_cnt, 0);
        send_one("post_rst", 24'h800001, 8'd0, 1'b1, 24'h345678, 24'h345678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
